flit_inject_buffer: RTL and testbench
=====================================

// Module: flit_inject_buffer
// PURPOSE
//  Elastic, packet-aware buffer between a testbench packet source (MA/App parser) and a many-core injection port.
//  Decouples parser pacing from NoC back-pressure with a DEPTH-flit FIFO.
//  Tracks header/size/payload framing on the egress side and reports packet boundaries and counts.
//  Both sides use the NoC tx/credit handshake.
// PARAMETERS
//  FLIT_SIZE  32  flit width in bits
//  DEPTH      8   FIFO depth in flits; power of two, >= 2
//  CNT_W      16  width of the packet/flit statistics counters
// PORTS
//  clk_i        in   1          clock, all logic on rising edge
//  rst_i        in   1          asynchronous, active-high reset
//  rx_i         in   1          ingress flit valid (from parser tx_o)
//  credit_o     out  1          ingress credit; flit accepted when rx_i && credit_o
//  data_i       in   FLIT_SIZE  ingress flit
//  hold_i       in   1          1 = do not start a new egress packet (an in-flight packet still drains)
//  tx_o         out  1          egress flit valid (to MC *_src_rx_i)
//  credit_i     in   1          egress credit; flit consumed when tx_o && credit_i
//  data_o       out  FLIT_SIZE  egress flit (FIFO head, first-word fall-through)
//  sop_o        out  1          data_o is a header flit
//  eop_o        out  1          data_o is the last flit of its packet
//  busy_o       out  1          FIFO non-empty or egress FSM not in HEADER
//  pkt_cnt_o    out  CNT_W      packets fully sent since reset (wraps)
//  flit_cnt_o   out  CNT_W      flits sent since reset (wraps)
// BEHAVIOUR
//  Reset: FIFO flushed (rd/wr ptr, count = 0), FSM = HEADER, counters = 0.
//    Outputs during and after reset: tx_o=0, credit_o=1, data_o=0, sop_o=0, eop_o=0, busy_o=0.
//  Reset mid-packet discards buffered flits and framing state, with no partial completion counted.
//  Ingress: credit_o = (count != DEPTH), combinational from registered count.
//    rx_i while credit_o=0 is ignored; no flit is written.
//  Egress: data_o = mem[rd_ptr].
//    tx_o = (count != 0) && !(FSM==HEADER && hold_i).
//    A flit written at cycle t can appear on tx_o at t+1 at the earliest (1-cycle latency).
//  Pointers wrap modulo DEPTH. A simultaneous write and read leaves count unchanged, including when count==DEPTH-1 or 1.
//  When full, credit_o=0 the same cycle, so a read at full frees one slot visible the next cycle.
//  Packet format: flit0 = header (target addr in [15:0]), flit1 = payload size N (unsigned, full flit), then N payload flits.
//  Egress FSM (advances only on tx_o && credit_i):
//    HEADER  -> SIZE                                  sop_o=1
//    SIZE    -> PAYLOAD, remaining <= N               eop_o=1 iff N==0, in which case -> HEADER
//    PAYLOAD -> remaining <= remaining-1; -> HEADER when remaining==1   eop_o=1 iff remaining==1
//  remaining is a FLIT_SIZE-bit down-counter and never underflows.
//  sop_o and eop_o are qualified by tx_o (0 when tx_o=0).
//  On an eop transfer: pkt_cnt_o+1. On every transfer: flit_cnt_o+1. Both wrap at 2^CNT_W.
//  hold_i is sampled only in HEADER; asserting it mid-packet does not stall the packet.
//  An empty FIFO mid-packet stalls (tx_o=0) with the FSM state held.
// TESTING
//  1. Reset then idle -> tx_o=0, credit_o=1, busy_o=0, counters 0.
//  2. Push {0x0101, 2, 0xA, 0xB} with credit_i=1 -> 4 egress flits on consecutive cycles, first 1 cycle after first push;
//     sop_o on 0x0101, eop_o on 0xB; pkt_cnt_o=1, flit_cnt_o=4.
//  3. credit_i=0, push DEPTH=8 flits -> credit_o=0 after the 8th; 9th rx_i ignored;
//     then credit_i=1 -> exactly 8 flits out, in order.
//  4. Packet {0x0202, 0} -> eop_o on the size flit; FSM back to HEADER; pkt_cnt_o+1.
//  5. hold_i=1 with a packet buffered -> tx_o=0. Release -> packet flows.
//     Raising hold_i after the header transfer does not stall the payload.
//  6. Assert rst_i mid-payload (3 flits buffered) -> tx_o=0 and count=0 immediately; pkt_cnt_o unchanged at 0;
//     next packet framed correctly from HEADER.

Source files
------------

// File: rtl/flit_inject_buffer.sv
// flit_inject_buffer
//   Elastic, packet-aware FIFO between a packet source (parser) and a
//   many-core injection port. Both sides use the tx/credit handshake. On the
//   egress side a small FSM follows header/size/payload framing. It flags
//   packet boundaries (sop_o/eop_o) and counts sent flits and packets.
//
// Ports
//   clk_i       clock, rising edge
//   rst_i       asynchronous active-high reset
//   rx_i        ingress flit valid
//   credit_o    ingress credit (flit accepted when rx_i && credit_o)
//   data_i      ingress flit
//   hold_i      blocks the start of a new egress packet (sampled in HEADER only)
//   tx_o        egress flit valid
//   credit_i    egress credit (flit consumed when tx_o && credit_i)
//   data_o      egress flit, FIFO head (first-word fall-through)
//   sop_o       data_o is a header flit
//   eop_o       data_o is the last flit of its packet
//   busy_o      FIFO non-empty or a packet is in flight
//   pkt_cnt_o   packets fully sent since reset (wraps)
//   flit_cnt_o  flits sent since reset (wraps)
module flit_inject_buffer #(
  parameter int FLIT_SIZE = 32,
  parameter int DEPTH     = 8,
  parameter int CNT_W     = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_i,
  output logic                 credit_o,
  input  logic [FLIT_SIZE-1:0] data_i,
  input  logic                 hold_i,
  output logic                 tx_o,
  input  logic                 credit_i,
  output logic [FLIT_SIZE-1:0] data_o,
  output logic                 sop_o,
  output logic                 eop_o,
  output logic                 busy_o,
  output logic [CNT_W-1:0]     pkt_cnt_o,
  output logic [CNT_W-1:0]     flit_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_HEADER  = 2'd0,
    ST_SIZE    = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_t;

  logic [FLIT_SIZE-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg;
  logic [PTR_W-1:0]     rd_ptr_reg;
  logic [PTR_W:0]       count_reg;
  state_t               state_reg;
  state_t               state_next;
  logic [FLIT_SIZE-1:0] remaining_reg;
  logic [FLIT_SIZE-1:0] remaining_next;
  logic [CNT_W-1:0]     pkt_cnt_reg;
  logic [CNT_W-1:0]     flit_cnt_reg;

  logic not_empty;
  logic wr_en;
  logic rd_en;
  logic eop_flit;

  assign not_empty = (count_reg != '0);
  assign credit_o  = (count_reg != FULL_CNT);
  assign wr_en     = rx_i && credit_o;
  assign tx_o      = not_empty && !((state_reg == ST_HEADER) && hold_i);
  assign rd_en     = tx_o && credit_i;

  // Gated on occupancy so the unreset storage never leaks onto data_o after
  // reset or once the FIFO has drained.
  assign data_o = not_empty ? mem[rd_ptr_reg] : '0;

  // Framing decode of the current head flit, independent of tx_o.
  assign eop_flit = ((state_reg == ST_SIZE) && (data_o == '0)) ||
                    ((state_reg == ST_PAYLOAD) && (remaining_reg == FLIT_SIZE'(1)));

  assign sop_o      = tx_o && (state_reg == ST_HEADER);
  assign eop_o      = tx_o && eop_flit;
  assign busy_o     = not_empty || (state_reg != ST_HEADER);
  assign pkt_cnt_o  = pkt_cnt_reg;
  assign flit_cnt_o = flit_cnt_reg;

  // Storage has no reset; the pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      state_reg     <= ST_HEADER;
      remaining_reg <= '0;
      pkt_cnt_reg   <= '0;
      flit_cnt_reg  <= '0;
    end else begin
      // Pointers are PTR_W bits wide and DEPTH is a power of two, so they
      // wrap naturally.
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (wr_en && !rd_en) begin
        count_reg <= count_reg + 1'b1;
      end else if (rd_en && !wr_en) begin
        count_reg <= count_reg - 1'b1;
      end
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      if (rd_en) begin
        flit_cnt_reg <= flit_cnt_reg + 1'b1;
        if (eop_flit) pkt_cnt_reg <= pkt_cnt_reg + 1'b1;
      end
    end
  end

  // Egress framing FSM; advances only on an actual transfer.
  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    case (state_reg)
      ST_HEADER: begin
        if (rd_en) state_next = ST_SIZE;
      end
      ST_SIZE: begin
        if (rd_en) begin
          remaining_next = data_o;
          state_next     = (data_o == '0) ? ST_HEADER : ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (rd_en) begin
          // remaining is at least 1 in PAYLOAD; the guard keeps it from
          // ever wrapping below zero.
          if (remaining_reg != '0) remaining_next = remaining_reg - 1'b1;
          if (remaining_reg <= FLIT_SIZE'(1)) state_next = ST_HEADER;
        end
      end
      default: begin
        state_next = ST_HEADER;
      end
    endcase
  end

endmodule

// File: tb/tb_flit_inject_buffer.sv
module tb_flit_inject_buffer;

  localparam int FLIT_SIZE = 32;
  localparam int DEPTH     = 8;
  localparam int CNT_W     = 16;

  logic                 clk_i;
  logic                 rst_i;
  logic                 rx_i;
  logic                 credit_o;
  logic [FLIT_SIZE-1:0] data_i;
  logic                 hold_i;
  logic                 tx_o;
  logic                 credit_i;
  logic [FLIT_SIZE-1:0] data_o;
  logic                 sop_o;
  logic                 eop_o;
  logic                 busy_o;
  logic [CNT_W-1:0]     pkt_cnt_o;
  logic [CNT_W-1:0]     flit_cnt_o;

  int n_checks;
  int n_pass;

  flit_inject_buffer #(
    .FLIT_SIZE(FLIT_SIZE),
    .DEPTH    (DEPTH),
    .CNT_W    (CNT_W)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .rx_i      (rx_i),
    .credit_o  (credit_o),
    .data_i    (data_i),
    .hold_i    (hold_i),
    .tx_o      (tx_o),
    .credit_i  (credit_i),
    .data_o    (data_o),
    .sop_o     (sop_o),
    .eop_o     (eop_o),
    .busy_o    (busy_o),
    .pkt_cnt_o (pkt_cnt_o),
    .flit_cnt_o(flit_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // One line per egress transfer.
  always @(negedge clk_i) begin
    if (!rst_i && tx_o && credit_i)
      $display("xfer data=%08h sop=%0d eop=%0d", data_o, sop_o, eop_o);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock, apply new inputs 1 ns after the edge, settle 1 ns.
  task automatic step(input logic rx, input logic [31:0] d, input logic cr, input logic hold);
    @(posedge clk_i);
    #1;
    rx_i     = rx;
    data_i   = d;
    credit_i = cr;
    hold_i   = hold;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_i    = 1'b1;
    rx_i     = 1'b0;
    data_i   = '0;
    credit_i = 1'b0;
    hold_i   = 1'b0;
    #2;
    // During reset
    chk("rst_tx", 32'(tx_o), 32'd0);
    chk("rst_credit", 32'(credit_o), 32'd1);
    chk("rst_data", data_o, 32'd0);
    chk("rst_sop", 32'(sop_o), 32'd0);
    chk("rst_eop", 32'(eop_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // 1. idle after reset
    step(0, 0, 0, 0);
    chk("idle_tx", 32'(tx_o), 32'd0);
    chk("idle_credit", 32'(credit_o), 32'd1);
    chk("idle_busy", 32'(busy_o), 32'd0);
    chk("idle_pkt", 32'(pkt_cnt_o), 32'd0);
    chk("idle_flit", 32'(flit_cnt_o), 32'd0);

    // 2. basic packet {0x0101, 2, A, B}, streaming with credit
    step(1, 32'h0101, 1, 0);
    chk("p2_tx0", 32'(tx_o), 32'd0);
    step(1, 32'd2, 1, 0);
    chk("p2_tx1", 32'(tx_o), 32'd1);
    chk("p2_hdr", data_o, 32'h0101);
    chk("p2_sop", 32'(sop_o), 32'd1);
    chk("p2_eop_hdr", 32'(eop_o), 32'd0);
    step(1, 32'hA, 1, 0);
    chk("p2_size", data_o, 32'd2);
    chk("p2_sop_size", 32'(sop_o), 32'd0);
    chk("p2_eop_size", 32'(eop_o), 32'd0);
    step(1, 32'hB, 1, 0);
    chk("p2_pl0", data_o, 32'hA);
    chk("p2_eop_pl0", 32'(eop_o), 32'd0);
    step(0, 0, 1, 0);
    chk("p2_pl1", data_o, 32'hB);
    chk("p2_tx_pl1", 32'(tx_o), 32'd1);
    chk("p2_eop_pl1", 32'(eop_o), 32'd1);
    step(0, 0, 1, 0);
    chk("p2_tx_done", 32'(tx_o), 32'd0);
    chk("p2_pkt", 32'(pkt_cnt_o), 32'd1);
    chk("p2_flit", 32'(flit_cnt_o), 32'd4);
    chk("p2_busy", 32'(busy_o), 32'd0);

    // 3. fill to DEPTH with egress blocked: {0x0303, 6, 1..6}
    step(1, 32'h0303, 0, 0);
    chk("p3_credit_start", 32'(credit_o), 32'd1);
    step(1, 32'd6, 0, 0);
    for (int i = 1; i <= 6; i++) begin
      step(1, 32'(i), 0, 0);
      chk("p3_credit_fill", 32'(credit_o), 32'd1);
    end
    // count is now 8; the 9th rx_i must be ignored
    step(1, 32'hDEAD, 0, 0);
    chk("p3_credit_full", 32'(credit_o), 32'd0);
    chk("p3_tx_full", 32'(tx_o), 32'd1);
    chk("p3_busy_full", 32'(busy_o), 32'd1);
    step(0, 0, 1, 0);
    chk("p3_credit_rd_full", 32'(credit_o), 32'd0);
    chk("p3_o_hdr", data_o, 32'h0303);
    chk("p3_o_sop", 32'(sop_o), 32'd1);
    step(0, 0, 1, 0);
    chk("p3_credit_freed", 32'(credit_o), 32'd1);
    chk("p3_o_size", data_o, 32'd6);
    for (int i = 1; i <= 6; i++) begin
      step(0, 0, 1, 0);
      chk("p3_o_pl", data_o, 32'(i));
      chk("p3_o_eop", 32'(eop_o), (i == 6) ? 32'd1 : 32'd0);
    end
    step(0, 0, 1, 0);
    chk("p3_tx_drained", 32'(tx_o), 32'd0);
    chk("p3_pkt", 32'(pkt_cnt_o), 32'd2);
    chk("p3_flit", 32'(flit_cnt_o), 32'd12);

    // 4. zero-length packet {0x0202, 0}
    step(1, 32'h0202, 1, 0);
    step(1, 32'd0, 1, 0);
    chk("p4_hdr", data_o, 32'h0202);
    chk("p4_sop", 32'(sop_o), 32'd1);
    step(0, 0, 1, 0);
    chk("p4_size", data_o, 32'd0);
    chk("p4_eop", 32'(eop_o), 32'd1);
    chk("p4_tx", 32'(tx_o), 32'd1);
    step(0, 0, 1, 0);
    chk("p4_busy", 32'(busy_o), 32'd0);
    chk("p4_pkt", 32'(pkt_cnt_o), 32'd3);
    chk("p4_flit", 32'(flit_cnt_o), 32'd14);

    // 5. hold_i: {0x0404, 1, 0x55}
    step(1, 32'h0404, 1, 1);
    step(1, 32'd1, 1, 1);
    chk("p5_hold_tx", 32'(tx_o), 32'd0);
    chk("p5_hold_busy", 32'(busy_o), 32'd1);
    chk("p5_hold_sop", 32'(sop_o), 32'd0);
    step(1, 32'h55, 1, 1);
    chk("p5_hold_tx2", 32'(tx_o), 32'd0);
    step(0, 0, 1, 1);
    chk("p5_hold_tx3", 32'(tx_o), 32'd0);
    step(0, 0, 1, 0);
    chk("p5_rel_tx", 32'(tx_o), 32'd1);
    chk("p5_rel_hdr", data_o, 32'h0404);
    chk("p5_rel_sop", 32'(sop_o), 32'd1);
    step(0, 0, 1, 1);
    chk("p5_mid_tx_size", 32'(tx_o), 32'd1);
    chk("p5_mid_size", data_o, 32'd1);
    step(0, 0, 1, 1);
    chk("p5_mid_tx_pl", 32'(tx_o), 32'd1);
    chk("p5_mid_pl", data_o, 32'h55);
    chk("p5_mid_eop", 32'(eop_o), 32'd1);
    step(0, 0, 1, 0);
    chk("p5_tx_done", 32'(tx_o), 32'd0);
    chk("p5_pkt", 32'(pkt_cnt_o), 32'd4);
    chk("p5_flit", 32'(flit_cnt_o), 32'd17);

    // 6. reset mid-payload: {0x0606, 5, 0x61, 0x62, 0x63} buffered
    step(1, 32'h0606, 0, 0);
    step(1, 32'd5, 0, 0);
    step(1, 32'h61, 0, 0);
    step(1, 32'h62, 0, 0);
    step(1, 32'h63, 0, 0);
    step(0, 0, 1, 0);
    chk("p6_hdr", data_o, 32'h0606);
    step(0, 0, 1, 0);
    chk("p6_size", data_o, 32'd5);
    step(0, 0, 0, 0);
    chk("p6_pl_head", data_o, 32'h61);
    chk("p6_busy_mid", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    #1;
    chk("p6_rst_tx", 32'(tx_o), 32'd0);
    chk("p6_rst_busy", 32'(busy_o), 32'd0);
    chk("p6_rst_credit", 32'(credit_o), 32'd1);
    chk("p6_rst_data", data_o, 32'd0);
    chk("p6_rst_pkt", 32'(pkt_cnt_o), 32'd0);
    chk("p6_rst_flit", 32'(flit_cnt_o), 32'd0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    // next packet {0x0707, 1, 0x71} framed from HEADER
    step(1, 32'h0707, 1, 0);
    chk("p6_new_tx0", 32'(tx_o), 32'd0);
    step(1, 32'd1, 1, 0);
    chk("p6_new_hdr", data_o, 32'h0707);
    chk("p6_new_sop", 32'(sop_o), 32'd1);
    step(1, 32'h71, 1, 0);
    chk("p6_new_size", data_o, 32'd1);
    chk("p6_new_eop_size", 32'(eop_o), 32'd0);
    step(0, 0, 1, 0);
    chk("p6_new_pl", data_o, 32'h71);
    chk("p6_new_eop", 32'(eop_o), 32'd1);
    step(0, 0, 1, 0);
    chk("p6_new_pkt", 32'(pkt_cnt_o), 32'd1);
    chk("p6_new_flit", 32'(flit_cnt_o), 32'd3);
    chk("p6_new_busy", 32'(busy_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
